// File: rtl/ram_memory_if.sv
// rtl/ram_memory_if.sv - access bus between the datapath wrapper and ram_memory
interface ram_memory_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  wren;
   logic [DATA_WIDTH-1:0] data_out;

   modport master (
      output address,
      output data_in,
      output wren,
      input  data_out
   );

   modport slave (
      input  address,
      input  data_in,
      input  wren,
      output data_out
   );
endinterface

// File: rtl/ram_memory.sv
// rtl/ram_memory.sv - single-port synchronous RAM with registered, write-through read data
module ram_memory #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic         clock,
   input  logic         reset,
   ram_memory_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // The array is zero at power-up; reset leaves stored contents alone.
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   always_ff @(posedge clock) begin
      if (!reset && bus.wren) begin
         mem[bus.address] <= bus.data_in;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.data_out <= '0;
      end else if (bus.wren) begin
         bus.data_out <= bus.data_in;
      end else begin
         bus.data_out <= mem[bus.address];
      end
   end
endmodule

// File: tb/tb_ram_memory.sv
// tb/tb_ram_memory.sv - directed self-checking bench for ram_memory
module tb_ram_memory;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   ram_memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

   ram_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: data_out=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d, input string tag);
      bus.address = a;
      bus.data_in = d;
      bus.wren    = 1'b1;
      step();
      check_eq(tag, bus.data_out, d);
   endtask

   task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
      bus.address = a;
      bus.data_in = 8'h00;
      bus.wren    = 1'b0;
      step();
      check_eq(tag, bus.data_out, exp);
   endtask

   initial begin
      bus.address = 8'h00;
      bus.data_in = 8'h00;
      bus.wren    = 1'b0;
      #1;
      check_eq("reset_out", bus.data_out, 8'h00);
      step();
      check_eq("reset_hold", bus.data_out, 8'h00);
      reset = 1'b0;

      do_write(8'h0F, 8'h1E, "wr_0f_thru");
      do_write(8'hF0, 8'h03, "wr_f0_thru");
      do_read (8'h0F, 8'h1E, "rd_0f");
      do_read (8'hF0, 8'h03, "rd_f0");

      do_write(8'h20, 8'hA5, "wr_20_thru");
      do_read (8'h20, 8'hA5, "rd_20");

      do_write(8'h00, 8'h11, "wr_00_thru");
      do_write(8'hFF, 8'hEE, "wr_ff_thru");
      do_read (8'h00, 8'h11, "rd_00");
      do_read (8'hFF, 8'hEE, "rd_ff");

      do_read (8'h55, 8'h00, "rd_unwritten");

      do_write(8'h10, 8'h01, "wr_10_a");
      do_write(8'h10, 8'h02, "wr_10_b");
      do_read (8'h10, 8'h02, "rd_10_last");

      // data_out must hold between edges even when inputs change
      do_read (8'h0F, 8'h1E, "rd_0f_pre_rst");
      bus.address = 8'h55;
      #2;
      check_eq("hold_between_edges", bus.data_out, 8'h1E);
      reset = 1'b1;
      #1;
      check_eq("async_rst_clear", bus.data_out, 8'h00);
      step();
      reset = 1'b0;
      do_read (8'h0F, 8'h1E, "rd_0f_after_rst");

      reset       = 1'b1;
      bus.address = 8'h0F;
      bus.data_in = 8'hFF;
      bus.wren    = 1'b1;
      step();
      check_eq("rst_blocks_wr_out", bus.data_out, 8'h00);
      reset = 1'b0;
      do_read (8'h0F, 8'h1E, "rd_0f_wr_blocked");
      do_read (8'h20, 8'hA5, "rd_20_retained");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
